// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the fetch/data memory-bus arbiter.
//   state_t    : arbiter FSM encoding (IDLE, BUSY_I, BUSY_D)
//   req_id_t   : requester identity used for round-robin bookkeeping
//   RW_DEF     : default address / data-port word width
//   I_SIZE_DEF : default instruction width (also memory read-data width)
package mem_arbiter_pkg;

  localparam int RW_DEF     = 16;
  localparam int I_SIZE_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// mem_arbiter_rr_arb2
// Two-input round-robin picker. A requester is eligible when its request is
// high and its block bit is low. On a tie the winner is the requester that
// did not win last time.
// Ports:
//   req_i, req_d     : raw requests (fetch, data)
//   block_i, block_d : per-requester mask for this decision
//   last_grant       : identity of the previous winner
//   gnt              : a winner exists
//   gnt_id           : identity of the winner (meaningful only with gnt)
module mem_arbiter_rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic    req_i,
  input  logic    req_d,
  input  logic    block_i,
  input  logic    block_d,
  input  req_id_t last_grant,
  output logic    gnt,
  output req_id_t gnt_id
);

  logic elig_i;
  logic elig_d;

  assign elig_i = req_i & ~block_i;
  assign elig_d = req_d & ~block_d;

  always_comb begin
    gnt    = elig_i | elig_d;
    gnt_id = REQ_I;
    if (elig_i && elig_d) begin
      gnt_id = (last_grant == REQ_D) ? REQ_I : REQ_D;
    end else if (elig_d) begin
      gnt_id = REQ_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one stb/ack memory bus between the instruction-fetch port and the
// load/store data port. One transaction is in flight at a time; address,
// write-enable and write-data are registered at grant and held until ack.
// Completion is returned as a one-cycle valid pulse to the owner.
//
// Handshake: a requester raises its req and holds it (with stable address /
// we / wdata for the data port) until its one-cycle valid pulse. The bus
// side keeps o_mem_req high for the whole transaction and treats a single
// cycle of i_mem_ack as completion; the next grant may be made on that same
// edge, so o_mem_req can stay high across back-to-back transactions.
//
// Ports:
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_i_req/i_i_addr        : fetch request and address
//   i_i_flush               : discard pending/in-flight fetch result
//   o_i_data/o_i_valid      : fetch result and completion pulse
//   i_d_req/i_d_we/i_d_addr/i_d_wdata : data request
//   o_d_rdata/o_d_valid     : data result and completion pulse
//   o_mem_req/o_mem_addr/o_mem_we/o_mem_wdata : registered bus outputs
//   i_mem_data/i_mem_ack    : bus read data and completion
//   o_state                 : current FSM state (debug)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RW     = RW_DEF,
  parameter int I_SIZE = I_SIZE_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_i_req,
  input  logic [RW-1:0]     i_i_addr,
  input  logic              i_i_flush,
  output logic [I_SIZE-1:0] o_i_data,
  output logic              o_i_valid,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [RW-1:0]     i_d_addr,
  input  logic [RW-1:0]     i_d_wdata,
  output logic [RW-1:0]     o_d_rdata,
  output logic              o_d_valid,
  output logic              o_mem_req,
  output logic [RW-1:0]     o_mem_addr,
  output logic              o_mem_we,
  output logic [RW-1:0]     o_mem_wdata,
  input  logic [I_SIZE-1:0] i_mem_data,
  input  logic              i_mem_ack,
  output state_t            o_state
);

  state_t        state_q, state_d;
  req_id_t       last_q, last_d;
  logic          flush_q, flush_d;
  logic          req_q, req_d;
  logic [RW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [RW-1:0] wdata_q, wdata_d;

  logic          arb_en;
  logic          block_i;
  logic          block_d;
  logic          gnt;
  req_id_t       gnt_id;

  // A decision is made in IDLE or on the ack edge of a busy transaction.
  assign arb_en  = (state_q == IDLE) | i_mem_ack;

  // The requester completing this cycle is not eligible: its next address
  // is not presented until the cycle after its valid pulse. A flush also
  // vetoes any fetch grant in the same cycle.
  assign block_i = i_i_flush | (state_q == BUSY_I);
  assign block_d = (state_q == BUSY_D);

  mem_arbiter_rr_arb2 u_rr (
    .req_i      (i_i_req),
    .req_d      (i_d_req),
    .block_i    (block_i),
    .block_d    (block_d),
    .last_grant (last_q),
    .gnt        (gnt),
    .gnt_id     (gnt_id)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      last_q  <= REQ_D;
      flush_q <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      flush_q <= flush_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    flush_d = flush_q;
    req_d   = req_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;

    // A flush during an in-flight fetch is remembered until that fetch's
    // ack so its result is dropped even if the flush pulse has gone.
    if (state_q == BUSY_I) begin
      if (i_mem_ack) begin
        flush_d = 1'b0;
      end else if (i_i_flush) begin
        flush_d = 1'b1;
      end
    end

    if (arb_en) begin
      if (gnt) begin
        last_d = gnt_id;
        req_d  = 1'b1;
        if (gnt_id == REQ_I) begin
          state_d = BUSY_I;
          addr_d  = i_i_addr;
          we_d    = 1'b0;
          wdata_d = '0;
        end else begin
          state_d = BUSY_D;
          addr_d  = i_d_addr;
          we_d    = i_d_we;
          wdata_d = i_d_wdata;
        end
      end else begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    end
  end

  assign o_mem_req   = req_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_we    = we_q;
  assign o_mem_wdata = wdata_q;

  assign o_i_data    = i_mem_data;
  assign o_i_valid   = i_mem_ack & (state_q == BUSY_I) & ~flush_q & ~i_i_flush;
  assign o_d_rdata   = i_mem_data[RW-1:0];
  assign o_d_valid   = i_mem_ack & (state_q == BUSY_D);
  assign o_state     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int RW     = 16;
  localparam int I_SIZE = 32;
  localparam int EW     = 35;
  localparam logic [1:0] K_I   = 2'd0;
  localparam logic [1:0] K_D   = 2'd1;
  localparam logic [1:0] K_IFL = 2'd2;

  logic              i_clk;
  logic              i_rst_n;
  logic              i_i_req;
  logic [RW-1:0]     i_i_addr;
  logic              i_i_flush;
  logic [I_SIZE-1:0] o_i_data;
  logic              o_i_valid;
  logic              i_d_req;
  logic              i_d_we;
  logic [RW-1:0]     i_d_addr;
  logic [RW-1:0]     i_d_wdata;
  logic [RW-1:0]     o_d_rdata;
  logic              o_d_valid;
  logic              o_mem_req;
  logic [RW-1:0]     o_mem_addr;
  logic              o_mem_we;
  logic [RW-1:0]     o_mem_wdata;
  logic [I_SIZE-1:0] i_mem_data = '0;
  logic              i_mem_ack  = 1'b0;
  state_t            o_state;

  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  int ack_delay = 1;
  int wait_cnt  = 0;
  int b2b_cnt   = 0;
  logic prev_req = 1'b0;
  logic prev_ack = 1'b0;
  logic [2*RW:0] held = '0;

  mem_arbiter #(.RW(RW), .I_SIZE(I_SIZE)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_i_req     (i_i_req),
    .i_i_addr    (i_i_addr),
    .i_i_flush   (i_i_flush),
    .o_i_data    (o_i_data),
    .o_i_valid   (o_i_valid),
    .i_d_req     (i_d_req),
    .i_d_we      (i_d_we),
    .i_d_addr    (i_d_addr),
    .i_d_wdata   (i_d_wdata),
    .o_d_rdata   (o_d_rdata),
    .o_d_valid   (o_d_valid),
    .o_mem_req   (o_mem_req),
    .o_mem_addr  (o_mem_addr),
    .o_mem_we    (o_mem_we),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_data  (i_mem_data),
    .i_mem_ack   (i_mem_ack),
    .o_state     (o_state)
  );

  // clock / reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [I_SIZE-1:0] mem_word(input logic [RW-1:0] a);
    return {16'hDEAD ^ a, 16'hBEEF ^ a};
  endfunction

  function automatic logic [EW-1:0] mk_exp(input logic [1:0] k, input logic we,
                                           input logic [RW-1:0] a, input logic [RW-1:0] wd);
    return {k, we, a, wd};
  endfunction

  // memory responder: acks after ack_delay cycles of o_mem_req
  always begin
    @(posedge i_clk);
    #2;
    if (!i_rst_n) begin
      wait_cnt  = 0;
      i_mem_ack = 1'b0;
    end else begin
      if (i_mem_ack) wait_cnt = 0;
      if (o_mem_req) begin
        wait_cnt++;
        i_mem_ack = (wait_cnt >= ack_delay);
        if (i_mem_ack) i_mem_data = mem_word(o_mem_addr);
      end else begin
        wait_cnt  = 0;
        i_mem_ack = 1'b0;
      end
    end
  end

  // scoreboard / bus monitor, sampled mid-cycle
  always begin
    logic [EW-1:0]     e;
    logic [1:0]        k;
    logic [I_SIZE-1:0] w;
    logic [RW-1:0]     w_lo;
    @(negedge i_clk);
    if (!i_rst_n) begin
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (o_mem_req && (!prev_req || prev_ack)) begin
        held = {o_mem_we, o_mem_addr, o_mem_wdata};
        if (prev_ack) b2b_cnt++;
      end else if (o_mem_req) begin
        checks++;
        if ({o_mem_we, o_mem_addr, o_mem_wdata} !== held) begin
          failures++;
          $display("FAIL bus_hold: got %h required %h", {o_mem_we, o_mem_addr, o_mem_wdata}, held);
        end
      end
      if (!i_mem_ack) begin
        checks++;
        if ({o_i_valid, o_d_valid} !== 2'b00) begin
          failures++;
          $display("FAIL spurious_valid: i=%b d=%b required 0 0", o_i_valid, o_d_valid);
        end
      end else if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack: addr %h with empty expected queue", o_mem_addr);
      end else begin
        e = exp_q.pop_front();
        k = e[34:33];
        w = mem_word(e[31:16]);
        w_lo = w[RW-1:0];
        checks++;
        if ({o_mem_we, o_mem_addr, o_mem_wdata} !== e[32:0]) begin
          failures++;
          $display("FAIL bus_fields: got %h required %h", {o_mem_we, o_mem_addr, o_mem_wdata}, e[32:0]);
        end
        checks++;
        if (o_i_valid !== (k == K_I)) begin
          failures++;
          $display("FAIL i_valid: got %b required %b (addr %h)", o_i_valid, (k == K_I), e[31:16]);
        end
        checks++;
        if (o_d_valid !== (k == K_D)) begin
          failures++;
          $display("FAIL d_valid: got %b required %b (addr %h)", o_d_valid, (k == K_D), e[31:16]);
        end
        if (k == K_I) begin
          checks++;
          if (o_i_data !== w) begin
            failures++;
            $display("FAIL i_data: got %h required %h", o_i_data, w);
          end
        end
        if (k == K_D && !e[32]) begin
          checks++;
          if (o_d_rdata !== w_lo) begin
            failures++;
            $display("FAIL d_rdata: got %h required %h", o_d_rdata, w_lo);
          end
        end
      end
      prev_req = o_mem_req;
      prev_ack = i_mem_ack;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset();
    i_rst_n   = 1'b0;
    i_i_req   = 1'b0;
    i_i_addr  = '0;
    i_i_flush = 1'b0;
    i_d_req   = 1'b0;
    i_d_we    = 1'b0;
    i_d_addr  = '0;
    i_d_wdata = '0;
    repeat (2) tick();
    i_rst_n = 1'b1;
    exp_q.delete();
    b2b_cnt = 0;
    tick();
  endtask

  task automatic wait_ack(input int max_cyc, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < max_cyc && !seen; k++) begin
      @(negedge i_clk);
      if (i_mem_ack) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_ack_timeout: no ack within %0d cycles", name, max_cyc);
    end
    tick();
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({o_mem_req, o_mem_addr, o_mem_we, o_mem_wdata, o_i_valid, o_d_valid} !== '0) begin
      failures++;
      $display("FAIL %s_outputs: req=%b addr=%h we=%b wdata=%h iv=%b dv=%b required all 0",
               name, o_mem_req, o_mem_addr, o_mem_we, o_mem_wdata, o_i_valid, o_d_valid);
    end
    checks++;
    if (o_state !== IDLE) begin
      failures++;
      $display("FAIL %s_state: got %0d required %0d", name, o_state, IDLE);
    end
  endtask

  // Both ports request continuously until n_i fetches and n_d data
  // accesses have completed. Grant order is predicted by a small
  // round-robin model (fetch wins the first tie after reset).
  task automatic run_traffic(input int n_i, input int n_d, input logic d_we,
                             input logic [RW-1:0] i_base, input logic [RW-1:0] d_base,
                             input logic [RW-1:0] wd_base, input string name);
    int rem_i, rem_d, qi, qd, i_done, d_done, cyc, b2b_exp;
    logic last_d, have_prev, prev_kind_d;
    bit gi, gd;
    rem_i = n_i; rem_d = n_d; qi = 0; qd = 0; b2b_exp = 0;
    last_d = 1'b1; have_prev = 1'b0; prev_kind_d = 1'b0;
    while (rem_i > 0 || rem_d > 0) begin
      if (rem_i > 0 && (rem_d == 0 || last_d)) begin
        exp_q.push_back(mk_exp(K_I, 1'b0, i_base + 16'(qi), '0));
        qi++; rem_i--; last_d = 1'b0;
      end else begin
        exp_q.push_back(mk_exp(K_D, d_we, d_base + 16'(qd), wd_base + 16'(qd)));
        qd++; rem_d--; last_d = 1'b1;
      end
      if (have_prev && (prev_kind_d != last_d)) b2b_exp++;
      have_prev = 1'b1;
      prev_kind_d = last_d;
    end
    b2b_cnt = 0;
    i_done = 0; d_done = 0; cyc = 0;
    i_i_addr  = i_base;
    i_i_req   = (n_i > 0);
    i_d_addr  = d_base;
    i_d_we    = d_we;
    i_d_wdata = wd_base;
    i_d_req   = (n_d > 0);
    while ((i_done < n_i || d_done < n_d) && cyc < 300) begin
      @(negedge i_clk);
      gi = o_i_valid;
      gd = o_d_valid;
      tick();
      cyc++;
      if (gi) begin
        i_done++;
        i_i_addr = i_base + 16'(i_done);
        if (i_done == n_i) i_i_req = 1'b0;
      end
      if (gd) begin
        d_done++;
        i_d_addr  = d_base + 16'(d_done);
        i_d_wdata = wd_base + 16'(d_done);
        if (d_done == n_d) i_d_req = 1'b0;
      end
    end
    i_i_req = 1'b0;
    i_d_req = 1'b0;
    checks++;
    if (cyc >= 300) begin
      failures++;
      $display("FAIL %s_timeout: i_done=%0d d_done=%0d required %0d %0d", name, i_done, d_done, n_i, n_d);
    end
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_leftover: %0d expected transactions never completed", name, exp_q.size());
    end
    checks++;
    if (o_mem_req !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_req: got %b required 0", name, o_mem_req);
    end
    checks++;
    if (b2b_cnt != b2b_exp) begin
      failures++;
      $display("FAIL %s_back_to_back: got %0d zero-bubble grants required %0d", name, b2b_cnt, b2b_exp);
    end
  endtask

  // tests
  task automatic test_reset();
    i_rst_n = 1'b0;
    i_i_req = 1'b0; i_i_addr = '0; i_i_flush = 1'b0;
    i_d_req = 1'b0; i_d_we = 1'b0; i_d_addr = '0; i_d_wdata = '0;
    repeat (3) tick();
    check_idle_outputs("reset_held");
    i_rst_n = 1'b1;
    repeat (2) tick();
    check_idle_outputs("reset_released");
  endtask

  task automatic test_fetch_only();
    ack_delay = 1;
    i_i_addr = 16'h0000;
    i_i_req  = 1'b1;
    exp_q.push_back(mk_exp(K_I, 1'b0, 16'h0000, '0));
    checks++;
    if (o_mem_req !== 1'b0) begin
      failures++;
      $display("FAIL fetch_comb_grant: o_mem_req got %b required 0 before the edge", o_mem_req);
    end
    tick();
    checks++;
    if (o_mem_req !== 1'b1) begin
      failures++;
      $display("FAIL fetch_latency: o_mem_req got %b required 1", o_mem_req);
    end
    wait_ack(20, "fetch0");
    i_i_addr = 16'h0001;
    exp_q.push_back(mk_exp(K_I, 1'b0, 16'h0001, '0));
    checks++;
    if (o_mem_req !== 1'b0) begin
      failures++;
      $display("FAIL fetch_bubble: o_mem_req got %b required 0", o_mem_req);
    end
    tick();
    checks++;
    if ({o_mem_req, o_mem_addr, o_mem_we} !== {1'b1, 16'h0001, 1'b0}) begin
      failures++;
      $display("FAIL fetch_second_issue: req/addr/we got %b/%h/%b required 1/0001/0",
               o_mem_req, o_mem_addr, o_mem_we);
    end
    wait_ack(20, "fetch1");
    i_i_req = 1'b0;
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0 || o_mem_req !== 1'b0) begin
      failures++;
      $display("FAIL fetch_done: queue %0d req %b required 0 0", exp_q.size(), o_mem_req);
    end
  endtask

  task automatic test_tie_write();
    apply_reset();
    ack_delay = 1;
    run_traffic(2, 1, 1'b1, 16'h0010, 16'h0100, 16'hABCD, "tie_write");
  endtask

  task automatic test_alternation();
    apply_reset();
    ack_delay = 2;
    run_traffic(4, 4, 1'b0, 16'h0200, 16'h0300, 16'h0000, "alternate");
  endtask

  task automatic test_flush();
    ack_delay = 3;
    // flush in IDLE vetoes the fetch grant of that cycle
    i_i_addr  = 16'h0030;
    i_i_req   = 1'b1;
    i_i_flush = 1'b1;
    tick();
    checks++;
    if (o_mem_req !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_block: o_mem_req got %b required 0", o_mem_req);
    end
    i_i_flush = 1'b0;
    exp_q.push_back(mk_exp(K_IFL, 1'b0, 16'h0030, '0));
    exp_q.push_back(mk_exp(K_I, 1'b0, 16'h0040, '0));
    tick();
    checks++;
    if ({o_mem_req, o_mem_addr} !== {1'b1, 16'h0030}) begin
      failures++;
      $display("FAIL flush_first_issue: req/addr got %b/%h required 1/0030", o_mem_req, o_mem_addr);
    end
    i_i_flush = 1'b1;
    i_i_addr  = 16'h0040;
    tick();
    i_i_flush = 1'b0;
    wait_ack(20, "flushed");
    checks++;
    if (o_mem_req !== 1'b0) begin
      failures++;
      $display("FAIL flush_after_ack: o_mem_req got %b required 0", o_mem_req);
    end
    tick();
    checks++;
    if ({o_mem_req, o_mem_addr, o_mem_we} !== {1'b1, 16'h0040, 1'b0}) begin
      failures++;
      $display("FAIL flush_redirect: req/addr/we got %b/%h/%b required 1/0040/0",
               o_mem_req, o_mem_addr, o_mem_we);
    end
    wait_ack(20, "redirect");
    i_i_req = 1'b0;
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL flush_leftover: %0d expected transactions never completed", exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    ack_delay = 10;
    i_d_addr  = 16'h0500;
    i_d_we    = 1'b0;
    i_d_wdata = 16'h5555;
    i_d_req   = 1'b1;
    tick();
    checks++;
    if ({o_mem_req, o_state} !== {1'b1, BUSY_D}) begin
      failures++;
      $display("FAIL areset_busy: req/state got %b/%0d required 1/%0d", o_mem_req, o_state, BUSY_D);
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    check_idle_outputs("areset_immediate");
    i_d_req = 1'b0;
    repeat (2) tick();
    i_rst_n = 1'b1;
    repeat (4) tick();
    check_idle_outputs("areset_released");
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL areset_queue: %0d entries required 0", exp_q.size());
    end
  endtask

  task automatic test_hold_stable();
    bit seen;
    int cyc;
    ack_delay = 5;
    exp_q.push_back(mk_exp(K_D, 1'b1, 16'h0600, 16'h1234));
    i_d_addr  = 16'h0600;
    i_d_we    = 1'b1;
    i_d_wdata = 16'h1234;
    i_d_req   = 1'b1;
    tick();
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 20) begin
      i_d_addr  = 16'h0600 ^ 16'($urandom_range(1, 16'hFFFF));
      i_d_wdata = 16'($urandom_range(0, 16'hFFFF));
      @(negedge i_clk);
      cyc++;
      if (i_mem_ack) seen = 1'b1;
      tick();
    end
    i_d_req = 1'b0;
    checks++;
    if (cyc != 5) begin
      failures++;
      $display("FAIL hold_ack_cycle: ack seen after %0d cycles required 5", cyc);
    end
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0 || o_mem_req !== 1'b0) begin
      failures++;
      $display("FAIL hold_done: queue %0d req %b required 0 0", exp_q.size(), o_mem_req);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_tie_write();
    test_alternation();
    test_flush();
    test_async_reset();
    test_hold_stable();
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
